alu_result_sender: RTL

- Consumer side of the ALU/CMP result interface.
- Captures a registered result word when its single-cycle valid flag pulses, splits the word into bytes, and streams them LSB-first over a valid/ready byte interface toward the UART TX path or TX FIFO.
- Sits between the ALU result registers and the transmit path in the system controller datapath.
- Tracks results that arrive while it is busy and cannot be accepted.

---
 rtl/alu_result_sender.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_result_sender.sv
// Consumer of the ALU/CMP result interface: captures a result on its valid pulse and
// streams it LSB-first as bytes over a valid/ready interface, counting overrun drops.
module alu_result_sender #(
   parameter int RES_WIDTH  = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [RES_WIDTH-1:0]  RES_DATA,
   input  logic                  RES_VALID,
   output logic [BYTE_WIDTH-1:0] TX_DATA,
   output logic                  TX_VALID,
   input  logic                  TX_READY,
   output logic                  BUSY,
   output logic                  DROP,
   output logic [CNT_WIDTH-1:0]  DROP_CNT,
   input  logic                  CLR_DROP
);

   localparam int NUM_BYTES  = (RES_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
   localparam int HOLD_WIDTH = NUM_BYTES * BYTE_WIDTH;
   localparam int IDX_WIDTH  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BYTES - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t                                 state_q, state_d;
   logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0]   hold_q, hold_d;
   logic [IDX_WIDTH-1:0]                   idx_q, idx_d;
   logic [BYTE_WIDTH-1:0]                  tx_data_q, tx_data_d;
   logic                                   tx_valid_q, tx_valid_d;
   logic                                   busy_q, busy_d;
   logic                                   drop_q, drop_d;
   logic [CNT_WIDTH-1:0]                   drop_cnt_q, drop_cnt_d;

   logic handshake;
   logic last_byte;

   assign handshake = tx_valid_q & TX_READY;
   assign last_byte = (idx_q == LAST_IDX);

   // NOTE: every signal driven here gets a default first, so no path can leave it
   // unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      idx_d      = idx_q;
      drop_d     = 1'b0;
      drop_cnt_d = drop_cnt_q;
      tx_data_d  = '0;

      unique case (state_q)
         IDLE: begin
            if (RES_VALID) begin
               hold_d  = HOLD_WIDTH'(RES_DATA);
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (handshake && last_byte) begin
               idx_d = '0;
               if (RES_VALID) begin
                  // Result arriving with the final handshake chains on without a gap.
                  hold_d = HOLD_WIDTH'(RES_DATA);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (handshake) begin
                  idx_d = idx_q + IDX_WIDTH'(1);
               end
               drop_d = RES_VALID;
            end
         end
         default: state_d = IDLE;
      endcase

      if (CLR_DROP) begin
         drop_cnt_d = '0;
      end else if (drop_d && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end

      tx_valid_d = (state_d == SEND);
      busy_d     = (state_d == SEND);
      if (tx_valid_d) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (idx_d == IDX_WIDTH'(b)) begin
               tx_data_d = hold_d[b];
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbours regardless of block ordering.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         idx_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign TX_DATA  = tx_data_q;
   assign TX_VALID = tx_valid_q;
   assign BUSY     = busy_q;
   assign DROP     = drop_q;
   assign DROP_CNT = drop_cnt_q;

endmodule
